// File: rtl/display_pkg.sv
// Shared types and helpers for the display source scheduler and related
// shared-resource controllers.
package display_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } disp_state_t;

  // Round-robin successor of ptr in a ring of num_src entries.
  function automatic int unsigned next_rr_ptr(input int unsigned ptr,
                                              input int unsigned num_src);
    return (ptr + 32'd1 >= num_src) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1 with wrap,
// first asserted request wins.
module rr_arbiter
  import display_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last,
  output logic                       grant_valid,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_SRC);

  always_comb begin
    int unsigned ptr;
    // NOTE: every combinational output gets a default first, so no path
    // through the loop can leave it unassigned and infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    ptr         = 32'(last);
    for (int i = 0; i < NUM_SRC; i++) begin
      ptr = next_rr_ptr(ptr, NUM_SRC);
      if (!grant_valid && req[ptr[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = ptr[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// Time-shares the seven-segment display between NUM_SRC requesters, holding
// each granted value for at least HOLD_CYCLES clocks.
module display_source_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic                       freeze,
  output logic [NUM_SRC-1:0]         src_ack,
  output logic [DATA_W-1:0]          number,
  output logic [$clog2(NUM_SRC)-1:0] active_src,
  output logic                       shown_valid,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

  disp_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] last;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_now;

  rr_arbiter #(
    .NUM_SRC(NUM_SRC)
  ) u_arb (
    .req        (src_req),
    .last       (last),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  // Arbitration points: any idle cycle, or the last cycle of a hold window.
  assign grant_now = !freeze && grant_valid && (state == IDLE || cnt == '0);
  assign busy      = (state == HOLD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= LAST_RST;
      number      <= '0;
      active_src  <= '0;
      src_ack     <= '0;
      shown_valid <= 1'b0;
    end else begin
      src_ack <= '0;
      if (grant_now) begin
        number      <= src_data[grant_idx*DATA_W +: DATA_W];
        active_src  <= grant_idx;
        src_ack     <= ONE_HOT0 << grant_idx;
        last        <= grant_idx;
        cnt         <= CNT_LOAD;
        shown_valid <= 1'b1;
        state       <= HOLD;
      end else if (state == HOLD && !freeze) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else           state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a behavioural model, for HOLD_CYCLES=4 and HOLD_CYCLES=1.
module tb_display_source_scheduler;

  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            freeze = 1'b0;
  logic [NS-1:0]   src_req = '0;
  logic [NS*32-1:0] src_data = '0;

  logic [NS-1:0] ack    [2];
  logic [31:0]   number [2];
  logic [1:0]    active [2];
  logic          valid  [2];
  logic          busy   [2];

  always #5 clk = ~clk;

  display_source_scheduler #(.NUM_SRC(NS), .HOLD_CYCLES(4)) dut_h4 (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data),
    .freeze(freeze), .src_ack(ack[0]), .number(number[0]),
    .active_src(active[0]), .shown_valid(valid[0]), .busy(busy[0])
  );

  display_source_scheduler #(.NUM_SRC(NS), .HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data),
    .freeze(freeze), .src_ack(ack[1]), .number(number[1]),
    .active_src(active[1]), .shown_valid(valid[1]), .busy(busy[1])
  );

  // Reference model state: what each display should show, and how many more
  // cycles the current value must stay before the next arbitration.
  logic [31:0]   m_number [2];
  logic [NS-1:0] m_ack    [2];
  int            m_active [2];
  bit            m_valid  [2];
  bit            m_busy   [2];
  int            m_rem    [2];
  int            m_last   [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [NS-1:0] keep_mask = '0;
  int gq0[$], gq0_t[$], gq1[$], gq1_t[$];

  function automatic int hold_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int idx_of(input logic [NS-1:0] v);
    int r = -1;
    for (int i = 0; i < NS; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input int k);
    m_number[k] = '0; m_ack[k] = '0; m_active[k] = 0; m_valid[k] = 0;
    m_busy[k] = 0; m_rem[k] = 0; m_last[k] = NS - 1;
  endtask

  task automatic model_edge();
    int w;
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = '0;
      if (!rst_n) model_reset(k);
      else if (!freeze) begin
        if (m_busy[k] && m_rem[k] > 0) m_rem[k]--;
        else begin
          w = -1;
          for (int o = 1; o <= NS; o++)
            if (w < 0 && src_req[(m_last[k] + o) % NS]) w = (m_last[k] + o) % NS;
          if (w >= 0) begin
            m_number[k] = src_data[w*32 +: 32];
            m_active[k] = w;
            m_ack[k]    = 4'b0001 << w;
            m_last[k]   = w;
            m_rem[k]    = hold_of(k) - 1;
            m_valid[k]  = 1;
            m_busy[k]   = 1;
          end else m_busy[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.h%0d.number", tag, hold_of(k)), number[k], m_number[k]);
      check($sformatf("%s.h%0d.ack", tag, hold_of(k)), 32'(ack[k]), 32'(m_ack[k]));
      check($sformatf("%s.h%0d.active", tag, hold_of(k)), 32'(active[k]), 32'(m_active[k]));
      check($sformatf("%s.h%0d.valid", tag, hold_of(k)), 32'(valid[k]), 32'(m_valid[k]));
      check($sformatf("%s.h%0d.busy", tag, hold_of(k)), 32'(busy[k]), 32'(m_busy[k]));
      check($sformatf("%s.h%0d.onehot", tag, hold_of(k)), 32'($onehot0(ack[k])), 32'd1);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_all("cyc");
    if (ack[0] != '0) begin gq0.push_back(idx_of(ack[0])); gq0_t.push_back(cyc); end
    if (ack[1] != '0) begin gq1.push_back(idx_of(ack[1])); gq1_t.push_back(cyc); end
  endtask

  task automatic step_drop();
    step();
    src_req = src_req & ~(ack[0] & ~keep_mask);
  endtask

  task automatic clear_queues();
    gq0.delete(); gq0_t.delete(); gq1.delete(); gq1_t.delete();
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Called just after an active edge; asserts reset mid-cycle.
  task automatic async_reset_pulse();
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) model_reset(k);
    compare_all("arst");
    check("arst.number", number[0], 32'h0);
    check("arst.busy", 32'(busy[0]), 32'd0);
    check("arst.valid", 32'(valid[0]), 32'd0);
    check("arst.ack", 32'(ack[0]), 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int bc;
    for (int k = 0; k < 2; k++) model_reset(k);

    // 1: reset, then idle with no requests
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    check("t1.number", number[0], 32'h0);
    check("t1.valid", 32'(valid[0]), 32'd0);
    check("t1.busy", 32'(busy[0]), 32'd0);

    // 2: single request from source 2
    src_data[2*32 +: 32] = 32'hDEADBEEF;
    src_req = 4'b0100;
    step();
    check("t2.number", number[0], 32'hDEADBEEF);
    check("t2.active", 32'(active[0]), 32'd2);
    check("t2.ack", 32'(ack[0]), 32'b0100);
    bc = int'(busy[0]);
    src_req = '0;
    repeat (5) begin step(); bc += int'(busy[0]); end
    check("t2.busy_cycles", bc, 4);
    check("t2.number_kept", number[0], 32'hDEADBEEF);
    check("t2.idle", 32'(busy[0]), 32'd0);

    // 3: all four contend from reset
    sync_reset();
    clear_queues();
    src_data = {32'h00C0FFEE, 32'hFFFFFFFF, 32'h87654321, 32'h12345678};
    keep_mask = '0;
    src_req = 4'hF;
    repeat (18) step_drop();
    check("t3.h4.count", gq0.size(), 4);
    if (gq0.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t3.h4.order%0d", i), gq0[i], i);
        if (i > 0) check($sformatf("t3.h4.gap%0d", i), gq0_t[i] - gq0_t[i-1], 4);
      end
    check("t3.h1.count_ge4", 32'(gq1.size() >= 4), 32'd1);
    if (gq1.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t3.h1.order%0d", i), gq1[i], i);
        if (i > 0) check($sformatf("t3.h1.gap%0d", i), gq1_t[i] - gq1_t[i-1], 1);
      end

    // 4: src1 holds its request, src3 joins during src1's hold
    clear_queues();
    src_data[1*32 +: 32] = 32'hA1A1A1A1;
    src_data[3*32 +: 32] = 32'hB3B3B3B3;
    keep_mask = 4'b0010;
    src_req = 4'b0010;
    step_drop();
    src_req[3] = 1'b1;
    repeat (12) step_drop();
    check("t4.count_ge3", 32'(gq0.size() >= 3), 32'd1);
    if (gq0.size() >= 3) begin
      check("t4.order0", gq0[0], 1);
      check("t4.order1", gq0[1], 3);
      check("t4.order2", gq0[2], 1);
    end
    src_req = '0;
    keep_mask = '0;
    repeat (6) step();

    // 5: freeze for three cycles mid-hold
    src_data[0 +: 32] = 32'h5555AAAA;
    src_req = 4'b0001;
    step_drop();
    bc = int'(busy[0]);
    step(); bc += int'(busy[0]);
    freeze = 1'b1;
    repeat (3) begin
      step();
      bc += int'(busy[0]);
      check("t5.freeze_ack", 32'(ack[0]), 32'd0);
      check("t5.freeze_number", number[0], 32'h5555AAAA);
    end
    freeze = 1'b0;
    repeat (6) begin step(); bc += int'(busy[0]); end
    check("t5.busy_cycles", bc, 7);

    // 6: async reset mid-hold with src0 and src2 requesting
    src_data[0 +: 32]    = 32'h0000C0DE;
    src_data[2*32 +: 32] = 32'h2222BEEF;
    keep_mask = 4'b0101;
    src_req = 4'b0101;
    step_drop(); step_drop();
    async_reset_pulse();
    clear_queues();
    keep_mask = '0;
    repeat (10) step_drop();
    check("t6.count_ge2", 32'(gq0.size() >= 2), 32'd1);
    if (gq0.size() >= 2) begin
      check("t6.first", gq0[0], 0);
      check("t6.second", gq0[1], 2);
    end

    // Random traffic: requesters mostly hold until acked, occasionally give up
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < NS; s++) begin
        if (!src_req[s]) begin
          if ($urandom_range(3) == 0) begin
            src_data[s*32 +: 32] = $urandom;
            src_req[s] = 1'b1;
          end
        end else if (ack[0][s] && $urandom_range(1) == 0) src_req[s] = 1'b0;
        else if ($urandom_range(63) == 0) src_req[s] = 1'b0;
      end
      freeze = ($urandom_range(7) == 0);
      if ($urandom_range(499) == 0) async_reset_pulse();
      else step();
    end
    freeze = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
